// File: rtl/rst_pkg.sv
// Shared constants, key-index maps, state enum and char helpers for the
// row/column substitution decrypter.
package rst_pkg;

  localparam logic [7:0] NUL_CHAR    = 8'h00;
  localparam logic [7:0] SPACE_CHAR  = 8'h20;
  localparam logic [7:0] UPPERCASE_A = 8'h41;
  localparam logic [7:0] UPPERCASE_Z = 8'h5A;
  localparam logic [7:0] LOWERCASE_A = 8'h61;
  localparam logic [7:0] LOWERCASE_Z = 8'h7A;
  localparam logic [7:0] DIGIT_0     = 8'h30;
  localparam logic [7:0] DIGIT_9     = 8'h39;

  localparam int KEY_LEN = 12;
  localparam int HDR_NUM = 6;

  typedef enum logic [2:0] {
    ST_NOKEY = 3'd0,
    ST_CHECK = 3'd1,
    ST_ROW   = 3'd2,
    ST_COL   = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  // Row header r (0-based) lives at key char k0,k10,k2,k8,k4,k6.
  function automatic logic [3:0] row_key_idx(input logic [2:0] r);
    case (r)
      3'd0:    return 4'd0;
      3'd1:    return 4'd10;
      3'd2:    return 4'd2;
      3'd3:    return 4'd8;
      3'd4:    return 4'd4;
      3'd5:    return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] col_key_idx(input logic [2:0] c);
    case (c)
      3'd0:    return 4'd1;
      3'd1:    return 4'd11;
      3'd2:    return 4'd3;
      3'd3:    return 4'd9;
      3'd4:    return 4'd5;
      3'd5:    return 4'd7;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic is_alnum(input logic [7:0] c);
    return ((c >= UPPERCASE_A) && (c <= UPPERCASE_Z)) ||
           ((c >= LOWERCASE_A) && (c <= LOWERCASE_Z)) ||
           ((c >= DIGIT_0) && (c <= DIGIT_9));
  endfunction

  // Cells 0..25 are a..z, cells 26..35 are 0..9.
  function automatic logic [7:0] decode_char(input logic [2:0] r, input logic [2:0] c);
    logic [5:0] idx;
    idx = ({3'b000, r} * 6'd6) + {3'b000, c};
    if (idx < 6'd26) begin
      return LOWERCASE_A + {2'b00, idx};
    end else begin
      return DIGIT_0 + {2'b00, idx - 6'd26};
    end
  endfunction

endpackage

// File: rtl/rst_key_check.sv
// Walks the latched key one char per cycle for 12 cycles, flagging
// non-alphanumeric chars and chars repeated at a higher index.
module rst_key_check
  import rst_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [95:0] key,
  output logic        done,
  output logic        err_repeated_char,
  output logic        err_invalid_key_char
);

  logic       active_q, active_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rep_q, rep_d;
  logic       inv_q, inv_d;
  logic [7:0] cur_s;
  logic       cur_rep_s;
  logic       cur_inv_s;

  // Flags include the char under test so the owner can latch them on done.
  always_comb begin
    cur_s     = key[{cnt_q, 3'b000} +: 8];
    cur_inv_s = !is_alnum(cur_s);
    cur_rep_s = 1'b0;
    for (int j = 0; j < KEY_LEN; j++) begin
      if ((4'(j) > cnt_q) && (key[8*j +: 8] == cur_s)) begin
        cur_rep_s = 1'b1;
      end else begin
        cur_rep_s = cur_rep_s;
      end
    end
    done                 = active_q && (cnt_q == 4'd11);
    err_repeated_char    = rep_q | (active_q & cur_rep_s);
    err_invalid_key_char = inv_q | (active_q & cur_inv_s);

    active_d = active_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    inv_d    = inv_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = 4'd0;
      rep_d    = 1'b0;
      inv_d    = 1'b0;
    end else if (active_q) begin
      rep_d    = err_repeated_char;
      inv_d    = err_invalid_key_char;
      active_d = !done;
      cnt_d    = done ? 4'd0 : (cnt_q + 4'd1);
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= 4'd0;
      rep_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      inv_q    <= inv_d;
    end
  end

endmodule

// File: rtl/rst_decrypt.sv
// Row/column substitution decrypter: validates a 12-char key, then maps
// ciphertext pairs to plaintext. Define RST_DEC_SPACE_PASS_EN to pass spaces through.
module rst_decrypt
  import rst_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] key_char,
  input  logic        key_load,
  input  logic [7:0]  ct_char,
  input  logic        ct_valid,
  output logic        ct_ready,
  output logic [7:0]  pt_char,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic        err_repeated_char,
  output logic        err_invalid_key_char,
  output logic        err_invalid_ct_char
);

  state_e      state_q, state_d;
  logic [95:0] key_q, key_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  pt_char_q, pt_char_d;
  logic        pt_valid_q, pt_valid_d;
  logic        ct_ready_q, ct_ready_d;
  logic        err_rep_q, err_rep_d;
  logic        err_key_q, err_key_d;
  logic        err_ct_q, err_ct_d;

  logic        chk_done_s, chk_rep_s, chk_inv_s;
  logic        row_hit_s, col_hit_s;
  logic [2:0]  row_sel_s, col_sel_s;
  logic        ct_fire_s, pt_fire_s;

  rst_key_check u_key_check (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (key_load),
    .key                  (key_q),
    .done                 (chk_done_s),
    .err_repeated_char    (chk_rep_s),
    .err_invalid_key_char (chk_inv_s)
  );

  // Header lookup; a validated key has unique chars so at most one hit each.
  always_comb begin
    row_hit_s = 1'b0;
    col_hit_s = 1'b0;
    row_sel_s = 3'd0;
    col_sel_s = 3'd0;
    for (int h = 0; h < HDR_NUM; h++) begin
      if (ct_char == key_q[{row_key_idx(3'(h)), 3'b000} +: 8]) begin
        row_hit_s = 1'b1;
        row_sel_s = 3'(h);
      end else begin
        row_hit_s = row_hit_s;
      end
      if (ct_char == key_q[{col_key_idx(3'(h)), 3'b000} +: 8]) begin
        col_hit_s = 1'b1;
        col_sel_s = 3'(h);
      end else begin
        col_hit_s = col_hit_s;
      end
    end
  end

  assign ct_fire_s = ct_valid && ct_ready_q;
  assign pt_fire_s = pt_valid_q && pt_ready;

  // Next-state logic; key_load overrides any handshake in the same cycle.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    row_d     = row_q;
    pt_char_d = pt_char_q;
    err_rep_d = err_rep_q;
    err_key_d = err_key_q;
    err_ct_d  = 1'b0;
    if (key_load) begin
      key_d     = key_char;
      state_d   = ST_CHECK;
      row_d     = 3'd0;
      pt_char_d = NUL_CHAR;
      err_rep_d = 1'b0;
      err_key_d = 1'b0;
    end else begin
      case (state_q)
        ST_NOKEY: state_d = ST_NOKEY;
        ST_CHECK: begin
          if (chk_done_s) begin
            err_rep_d = chk_rep_s;
            err_key_d = chk_inv_s;
            state_d   = (chk_rep_s || chk_inv_s) ? ST_NOKEY : ST_ROW;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_ROW: begin
          if (ct_fire_s) begin
`ifdef RST_DEC_SPACE_PASS_EN
            if (ct_char == SPACE_CHAR) begin
              pt_char_d = SPACE_CHAR;
              state_d   = ST_EMIT;
            end else
`endif
            if (row_hit_s) begin
              row_d   = row_sel_s;
              state_d = ST_COL;
            end else begin
              err_ct_d = 1'b1;
              state_d  = ST_ROW;
            end
          end else begin
            state_d = ST_ROW;
          end
        end
        ST_COL: begin
          if (ct_fire_s) begin
            if (col_hit_s) begin
              pt_char_d = decode_char(row_q, col_sel_s);
              state_d   = ST_EMIT;
            end else begin
              err_ct_d = 1'b1;
              state_d  = ST_ROW;
            end
          end else begin
            state_d = ST_COL;
          end
        end
        ST_EMIT: begin
          if (pt_fire_s) begin
            state_d = ST_ROW;
          end else begin
            state_d = ST_EMIT;
          end
        end
        default: state_d = ST_NOKEY;
      endcase
    end
    ct_ready_d = (state_d == ST_ROW) || (state_d == ST_COL);
    pt_valid_d = (state_d == ST_EMIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NOKEY;
      key_q      <= 96'h0;
      row_q      <= 3'd0;
      pt_char_q  <= NUL_CHAR;
      pt_valid_q <= 1'b0;
      ct_ready_q <= 1'b0;
      err_rep_q  <= 1'b0;
      err_key_q  <= 1'b0;
      err_ct_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      row_q      <= row_d;
      pt_char_q  <= pt_char_d;
      pt_valid_q <= pt_valid_d;
      ct_ready_q <= ct_ready_d;
      err_rep_q  <= err_rep_d;
      err_key_q  <= err_key_d;
      err_ct_q   <= err_ct_d;
    end
  end

  assign ct_ready             = ct_ready_q;
  assign pt_char              = pt_char_q;
  assign pt_valid             = pt_valid_q;
  assign err_repeated_char    = err_rep_q;
  assign err_invalid_key_char = err_key_q;
  assign err_invalid_ct_char  = err_ct_q;

endmodule

// File: tb/tb_rst_decrypt.sv
// Directed-vector bench for rst_decrypt with hand-computed plaintext.
module tb_rst_decrypt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] key_char;
  logic        key_load;
  logic [7:0]  ct_char;
  logic        ct_valid;
  logic        ct_ready;
  logic [7:0]  pt_char;
  logic        pt_valid;
  logic        pt_ready;
  logic        err_repeated_char;
  logic        err_invalid_key_char;
  logic        err_invalid_ct_char;

  int vectors = 0;
  int miscompares = 0;
  int pt_xfers = 0;

  rst_decrypt dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .key_char             (key_char),
    .key_load             (key_load),
    .ct_char              (ct_char),
    .ct_valid             (ct_valid),
    .ct_ready             (ct_ready),
    .pt_char              (pt_char),
    .pt_valid             (pt_valid),
    .pt_ready             (pt_ready),
    .err_repeated_char    (err_repeated_char),
    .err_invalid_key_char (err_invalid_key_char),
    .err_invalid_ct_char  (err_invalid_ct_char)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pt_valid && pt_ready) pt_xfers = pt_xfers + 1;
  end

  // A string literal holds its first char in the top byte; k0 must be the low byte.
  function automatic logic [95:0] mk_key(input logic [95:0] s);
    logic [95:0] k;
    for (int i = 0; i < 12; i++) k[8*i +: 8] = s[8*(11-i) +: 8];
    return k;
  endfunction

  task automatic load_key(input logic [95:0] s);
    @(posedge clk); #1;
    key_char = mk_key(s);
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic wait_ready();
    repeat (12) @(negedge clk);
    vectors++;
    if (ct_ready !== 1'b0) begin miscompares++; $display("FAIL chk_busy_ct_ready: got %b want 0", ct_ready); end
    @(negedge clk);
    vectors++;
    if ({ct_ready, err_repeated_char, err_invalid_key_char} !== 3'b100) begin
      miscompares++;
      $display("FAIL key_ok: got rdy/rep/inv=%b%b%b want 100", ct_ready, err_repeated_char, err_invalid_key_char);
    end
  endtask

  task automatic send_ct(input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    ct_char  = c;
    ct_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ct_ready === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ct_timeout: char %h never accepted, ct_ready=%b want 1", c, ct_ready); end
    @(posedge clk); #1;
    ct_valid = 1'b0;
  endtask

  task automatic recv_pt(input logic [7:0] exp);
    @(negedge clk);
    vectors++;
    if (pt_valid !== 1'b1) begin miscompares++; $display("FAIL pt_latency: pt_valid=%b want 1", pt_valid); end
    vectors++;
    if (pt_char !== exp) begin miscompares++; $display("FAIL pt_char: got %h want %h", pt_char, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_char = 96'h0; key_load = 1'b0;
    ct_char = 8'h00; ct_valid = 1'b0; pt_ready = 1'b1;
    #3;
    vectors++;
    if ({ct_ready, pt_valid, pt_char, err_repeated_char, err_invalid_key_char, err_invalid_ct_char} !== 13'h0) begin
      miscompares++; $display("FAIL reset_outputs: rdy=%b vld=%b pt=%h errs=%b%b%b want all 0",
        ct_ready, pt_valid, pt_char, err_repeated_char, err_invalid_key_char, err_invalid_ct_char);
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    ct_valid = 1'b1; ct_char = "a";
    repeat (3) @(negedge clk);
    vectors++;
    if ({ct_ready, pt_valid} !== 2'b00) begin miscompares++; $display("FAIL nokey_idle: rdy=%b vld=%b want 0 0", ct_ready, pt_valid); end
    ct_valid = 1'b0;
  endtask

  task automatic test_decode();
    load_key("abcdefghilmn");
    wait_ready();
    send_ct("a"); send_ct("b"); recv_pt("a");
    send_ct("m"); send_ct("n"); recv_pt("h");
    send_ct("g"); send_ct("h"); recv_pt("9");
    send_ct("e"); send_ct("d"); recv_pt("0");
  endtask

  task automatic test_bad_keys();
    load_key("abcdefghilma");
    repeat (12) @(negedge clk);
    vectors++;
    if (err_repeated_char !== 1'b0) begin miscompares++; $display("FAIL rep_early: got %b want 0", err_repeated_char); end
    @(negedge clk);
    vectors++;
    if ({err_repeated_char, err_invalid_key_char, ct_ready} !== 3'b100) begin
      miscompares++; $display("FAIL rep_key: rep/inv/rdy=%b%b%b want 100", err_repeated_char, err_invalid_key_char, ct_ready);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ({ct_ready, err_repeated_char} !== 2'b01) begin miscompares++; $display("FAIL rep_sticky: rdy/rep=%b%b want 01", ct_ready, err_repeated_char); end

    load_key("abcdefghilm!");
    @(negedge clk);
    vectors++;
    if (err_repeated_char !== 1'b0) begin miscompares++; $display("FAIL rep_clear: got %b want 0", err_repeated_char); end
    repeat (12) @(negedge clk);
    vectors++;
    if ({err_repeated_char, err_invalid_key_char, ct_ready} !== 3'b010) begin
      miscompares++; $display("FAIL inv_key: rep/inv/rdy=%b%b%b want 010", err_repeated_char, err_invalid_key_char, ct_ready);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (ct_ready !== 1'b0) begin miscompares++; $display("FAIL inv_key_rdy: got %b want 0", ct_ready); end
  endtask

  task automatic test_invalid_ct();
    load_key("abcdefghilmn");
    wait_ready();
    send_ct("e"); send_ct("c");
    @(negedge clk);
    vectors++;
    if ({err_invalid_ct_char, pt_valid, ct_ready} !== 3'b101) begin
      miscompares++; $display("FAIL bad_ct: err/vld/rdy=%b%b%b want 101", err_invalid_ct_char, pt_valid, ct_ready);
    end
    @(negedge clk);
    vectors++;
    if (err_invalid_ct_char !== 1'b0) begin miscompares++; $display("FAIL bad_ct_pulse: got %b want 0", err_invalid_ct_char); end
    send_ct("e"); send_ct("f"); recv_pt("2");
    send_ct(8'h20);
`ifdef RST_DEC_SPACE_PASS_EN
    recv_pt(8'h20);
`else
    @(negedge clk);
    vectors++;
    if ({err_invalid_ct_char, pt_valid} !== 2'b10) begin
      miscompares++; $display("FAIL space_ct: err/vld=%b%b want 10", err_invalid_ct_char, pt_valid);
    end
`endif
  endtask

  task automatic test_backpressure();
    int x0;
    pt_ready = 1'b0;
    send_ct("a"); send_ct("b");
    x0 = pt_xfers;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({pt_valid, pt_char, ct_ready} !== {1'b1, 8'h61, 1'b0}) begin
        miscompares++; $display("FAIL bp_hold[%0d]: vld=%b pt=%h rdy=%b want 1 61 0", i, pt_valid, pt_char, ct_ready);
      end
    end
    pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pt_valid, ct_ready} !== 2'b01) begin miscompares++; $display("FAIL bp_release: vld/rdy=%b%b want 01", pt_valid, ct_ready); end
    vectors++;
    if (pt_xfers - x0 !== 1) begin miscompares++; $display("FAIL bp_xfers: got %0d want 1", pt_xfers - x0); end
  endtask

  task automatic test_reset_mid_pair();
    send_ct("m");
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ct_ready, pt_valid, pt_char, err_repeated_char, err_invalid_key_char, err_invalid_ct_char} !== 13'h0) begin
      miscompares++; $display("FAIL async_reset: rdy=%b vld=%b pt=%h want all 0", ct_ready, pt_valid, pt_char);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ct_ready !== 1'b0) begin miscompares++; $display("FAIL post_reset_rdy: got %b want 0", ct_ready); end
    load_key("abcdefghilmn");
    wait_ready();
    send_ct("n");
    @(negedge clk);
    vectors++;
    if ({err_invalid_ct_char, pt_valid} !== 2'b10) begin
      miscompares++; $display("FAIL lone_n: err/vld=%b%b want 10", err_invalid_ct_char, pt_valid);
    end
    @(negedge clk);
    vectors++;
    if (pt_valid !== 1'b0) begin miscompares++; $display("FAIL lone_n_out: vld=%b want 0", pt_valid); end
    send_ct("a"); send_ct("b"); recv_pt("a");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 want 1");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_bad_keys();
    test_invalid_ct();
    test_backpressure();
    test_reset_mid_pair();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
